// File: rtl/exe_stage_mc_if.sv
// ID-side inputs and EXE/MEM-side outputs of the execute stage, bundled as one bus.
// slave = execute stage, master = surrounding pipeline (or bench).
interface exe_stage_mc_if #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int REG_ADDR_W = 4
);
  logic                  valid_in;
  logic                  flush;
  logic                  wb_en_in;
  logic                  mem_r_en_in;
  logic                  mem_w_en_in;
  logic                  s_bit;
  logic [3:0]            exec_cmd;
  logic [ADDR_W-1:0]     pc_in;
  logic [DATA_W-1:0]     val_r_n;
  logic [DATA_W-1:0]     val_2;
  logic [DATA_W-1:0]     val_r_m_in;
  logic [23:0]           signed_imm_24;
  logic [REG_ADDR_W-1:0] dest_in;
  logic [1:0]            fwd_sel_1;
  logic [1:0]            fwd_sel_2;
  logic [DATA_W-1:0]     fwd_mem_val;
  logic [DATA_W-1:0]     fwd_wb_val;
  logic [3:0]            status_in;

  logic                  stall_out;
  logic [3:0]            status_next;
  logic                  status_update;
  logic [ADDR_W-1:0]     branch_addr;
  logic                  wb_en_out;
  logic                  mem_r_en_out;
  logic                  mem_w_en_out;
  logic [DATA_W-1:0]     alu_res;
  logic [DATA_W-1:0]     val_r_m_out;
  logic [REG_ADDR_W-1:0] dest_out;

  modport slave (
    input  valid_in, flush, wb_en_in, mem_r_en_in, mem_w_en_in, s_bit, exec_cmd,
           pc_in, val_r_n, val_2, val_r_m_in, signed_imm_24, dest_in,
           fwd_sel_1, fwd_sel_2, fwd_mem_val, fwd_wb_val, status_in,
    output stall_out, status_next, status_update, branch_addr, wb_en_out,
           mem_r_en_out, mem_w_en_out, alu_res, val_r_m_out, dest_out
  );

  modport master (
    output valid_in, flush, wb_en_in, mem_r_en_in, mem_w_en_in, s_bit, exec_cmd,
           pc_in, val_r_n, val_2, val_r_m_in, signed_imm_24, dest_in,
           fwd_sel_1, fwd_sel_2, fwd_mem_val, fwd_wb_val, status_in,
    input  stall_out, status_next, status_update, branch_addr, wb_en_out,
           mem_r_en_out, mem_w_en_out, alu_res, val_r_m_out, dest_out
  );
endinterface

// File: rtl/exe_stage_mc.sv
// ARM execute stage: 1-cycle ALU, iterative MUL/MLA with upstream stall, branch adder,
// EXE/MEM pipe register. Define EXE_FWD_EN to enable operand forwarding muxes.
//
// state | meaning
// IDLE  | ALU ops pass straight through; MUL/MLA latches operands and stalls
// BUSY  | retire MUL_BPC multiplier bits per cycle, counter runs L-1 .. 0
// DONE  | product + accumulator goes into the pipe register, stall released
module exe_stage_mc #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int REG_ADDR_W = 4,
  parameter int MUL_BPC    = 1
) (
  input logic            clk,
  input logic            rst,
  exe_stage_mc_if.slave  bus
);
  localparam int L     = DATA_W / MUL_BPC;
  localparam int CNT_W = $clog2(L) + 1;

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_MUL = 4'b1010;
  localparam logic [3:0] CMD_MLA = 4'b1011;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t            state;
  logic [DATA_W-1:0] mcand, mplier, acc, prod;
  logic [CNT_W-1:0]  cnt;

  logic [DATA_W-1:0] op1, op_rm;
  logic [DATA_W-1:0] add_b, alu_val, mul_res, res;
  logic [DATA_W:0]   sum;
  logic              add_cin, is_arith, is_mul, result_cycle;
  logic [1:0]        unused_status;

  assign unused_status = bus.status_in[3:2];

`ifdef EXE_FWD_EN
  always_comb begin
    unique case (bus.fwd_sel_1)
      2'b01:   op1 = bus.fwd_mem_val;
      2'b10:   op1 = bus.fwd_wb_val;
      default: op1 = bus.val_r_n;
    endcase
    unique case (bus.fwd_sel_2)
      2'b01:   op_rm = bus.fwd_mem_val;
      2'b10:   op_rm = bus.fwd_wb_val;
      default: op_rm = bus.val_r_m_in;
    endcase
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{bus.fwd_sel_1, bus.fwd_sel_2, bus.fwd_mem_val, bus.fwd_wb_val};
  assign op1   = bus.val_r_n;
  assign op_rm = bus.val_r_m_in;
`endif

  function automatic logic [DATA_W-1:0] digit_mul(input logic [DATA_W-1:0] a,
                                                  input logic [MUL_BPC-1:0] d);
    logic [DATA_W-1:0] s;
    s = '0;
    for (int i = 0; i < MUL_BPC; i++)
      if (d[i]) s = s + (a << i);
    return s;
  endfunction

  assign is_mul   = (bus.exec_cmd == CMD_MUL) || (bus.exec_cmd == CMD_MLA);
  assign is_arith = (bus.exec_cmd == CMD_ADD) || (bus.exec_cmd == CMD_ADC) ||
                    (bus.exec_cmd == CMD_SUB) || (bus.exec_cmd == CMD_SBC);

  // Subtraction as op1 + ~op2 + cin so the carry out is directly NOT borrow.
  always_comb begin
    add_b   = bus.val_2;
    add_cin = 1'b0;
    unique case (bus.exec_cmd)
      CMD_ADC: add_cin = bus.status_in[1];
      CMD_SUB: begin add_b = ~bus.val_2; add_cin = 1'b1; end
      CMD_SBC: begin add_b = ~bus.val_2; add_cin = bus.status_in[1]; end
      default: ;
    endcase
    sum = {1'b0, op1} + {1'b0, add_b} + {{DATA_W{1'b0}}, add_cin};
  end

  always_comb begin
    alu_val = '0;
    unique case (bus.exec_cmd)
      CMD_MOV: alu_val = bus.val_2;
      CMD_MVN: alu_val = ~bus.val_2;
      CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: alu_val = sum[DATA_W-1:0];
      CMD_AND: alu_val = op1 & bus.val_2;
      CMD_ORR: alu_val = op1 | bus.val_2;
      CMD_EOR: alu_val = op1 ^ bus.val_2;
      default: alu_val = '0;
    endcase
  end

  assign mul_res      = prod + acc;
  assign res          = (state == DONE) ? mul_res : alu_val;
  assign result_cycle = ((state == IDLE) && !is_mul) || (state == DONE);

  assign bus.status_next[3] = res[DATA_W-1];
  assign bus.status_next[2] = (res == '0);
  assign bus.status_next[1] = is_arith ? sum[DATA_W] : bus.status_in[1];
  assign bus.status_next[0] = is_arith ?
      ((op1[DATA_W-1] == add_b[DATA_W-1]) && (sum[DATA_W-1] != op1[DATA_W-1])) :
      bus.status_in[0];

  assign bus.status_update = bus.s_bit && bus.valid_in && !bus.flush && result_cycle;
  assign bus.stall_out     = (state == BUSY) ||
                             ((state == IDLE) && bus.valid_in && is_mul && !bus.flush);

  assign bus.branch_addr = bus.pc_in +
      {{(ADDR_W-26){bus.signed_imm_24[23]}}, bus.signed_imm_24, 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      mcand            <= '0;
      mplier           <= '0;
      acc              <= '0;
      prod             <= '0;
      cnt              <= '0;
      bus.wb_en_out    <= 1'b0;
      bus.mem_r_en_out <= 1'b0;
      bus.mem_w_en_out <= 1'b0;
      bus.alu_res      <= '0;
      bus.val_r_m_out  <= '0;
      bus.dest_out     <= '0;
    end else begin
      // Bubble unless a result is produced below; data fields simply hold.
      bus.wb_en_out    <= 1'b0;
      bus.mem_r_en_out <= 1'b0;
      bus.mem_w_en_out <= 1'b0;
      if (bus.flush) begin
        state <= IDLE;
      end else begin
        if (bus.valid_in && result_cycle) begin
          bus.wb_en_out    <= bus.wb_en_in;
          bus.mem_r_en_out <= bus.mem_r_en_in;
          bus.mem_w_en_out <= bus.mem_w_en_in;
          bus.alu_res      <= res;
          bus.val_r_m_out  <= op_rm;
          bus.dest_out     <= bus.dest_in;
        end
        unique case (state)
          IDLE: if (bus.valid_in && is_mul) begin
            mcand  <= op1;
            mplier <= bus.val_2;
            acc    <= (bus.exec_cmd == CMD_MLA) ? op_rm : '0;
            prod   <= '0;
            cnt    <= CNT_W'(L - 1);
            state  <= BUSY;
          end
          BUSY: begin
            prod   <= prod + digit_mul(mcand, mplier[MUL_BPC-1:0]);
            mcand  <= mcand << MUL_BPC;
            mplier <= mplier >> MUL_BPC;
            if (cnt == '0) state <= DONE;
            else           cnt   <= cnt - 1'b1;
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_exe_stage_mc.sv
// Directed bench for exe_stage_mc: ALU flags, MLA/MUL latency and stall, flush, reset,
// forwarding (expectation follows EXE_FWD_EN) and branch target.
module tb_exe_stage_mc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  exe_stage_mc_if #(.DATA_W(32), .ADDR_W(32), .REG_ADDR_W(4)) b ();

  exe_stage_mc #(.DATA_W(32), .ADDR_W(32), .REG_ADDR_W(4), .MUL_BPC(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [3:0] cmd, input logic [31:0] v1, input logic [31:0] v2,
                    input logic [31:0] rm, input logic s, input logic [3:0] d);
    b.valid_in   = 1'b1;
    b.wb_en_in   = 1'b1;
    b.exec_cmd   = cmd;
    b.val_r_n    = v1;
    b.val_2      = v2;
    b.val_r_m_in = rm;
    b.s_bit      = s;
    b.dest_in    = d;
  endtask

  // Counts stalled cycles up to a bound; flags any non-bubble seen during the stall.
  task automatic run_mul(output int n, output int bub);
    n   = 0;
    bub = 0;
    #1;
    while (b.stall_out === 1'b1 && n < 100) begin
      n++;
      go();
      if (b.wb_en_out !== 1'b0) bub++;
    end
  endtask

  int n_st, n_bub;

  initial begin
    b.valid_in = 0; b.flush = 0; b.wb_en_in = 0; b.mem_r_en_in = 0; b.mem_w_en_in = 0;
    b.s_bit = 0; b.exec_cmd = 0; b.pc_in = 0; b.val_r_n = 0; b.val_2 = 0; b.val_r_m_in = 0;
    b.signed_imm_24 = 0; b.dest_in = 0; b.fwd_sel_1 = 0; b.fwd_sel_2 = 0;
    b.fwd_mem_val = 0; b.fwd_wb_val = 0; b.status_in = 0;

    go(); go();
    chk("rst_alu_res", b.alu_res, 0);
    chk("rst_wb_en", {31'b0, b.wb_en_out}, 0);
    chk("rst_dest", {28'b0, b.dest_out}, 0);
    chk("rst_stall", {31'b0, b.stall_out}, 0);
    rst = 1'b0;

    // ADD overflow
    b.status_in = 4'b0000;
    op(4'b0010, 32'h7FFF_FFFF, 32'h1, 0, 1, 4'd1);
    #1;
    chk("add_flags", {28'b0, b.status_next}, 32'h9);
    chk("add_upd", {31'b0, b.status_update}, 1);
    chk("add_stall", {31'b0, b.stall_out}, 0);
    go();
    chk("add_res", b.alu_res, 32'h8000_0000);
    chk("add_wb", {31'b0, b.wb_en_out}, 1);
    chk("add_dest", {28'b0, b.dest_out}, 1);

    // SUB equal operands
    op(4'b0100, 32'd5, 32'd5, 0, 1, 4'd2);
    #1;
    chk("sub_flags", {28'b0, b.status_next}, 32'h6);
    go();
    chk("sub_res", b.alu_res, 0);

    // SBC with C=0
    b.status_in = 4'b0000;
    op(4'b0101, 32'd5, 32'd2, 0, 1, 4'd2);
    #1;
    chk("sbc_flags", {28'b0, b.status_next}, 32'h2);
    go();
    chk("sbc_res", b.alu_res, 2);

    // AND keeps C,V from status_in
    b.status_in = 4'b0011;
    op(4'b0110, 32'h0000_F0F0, 32'h0000_0FF0, 0, 1, 4'd3);
    #1;
    chk("and_flags", {28'b0, b.status_next}, 32'h3);
    go();
    chk("and_res", b.alu_res, 32'h0000_00F0);

    // EOR without s_bit
    op(4'b1000, 32'hFF00_FF00, 32'h0FF0_0FF0, 0, 0, 4'd3);
    #1;
    chk("eor_noupd", {31'b0, b.status_update}, 0);
    go();
    chk("eor_res", b.alu_res, 32'hF0F0_F0F0);

    // MVN
    b.status_in = 4'b0000;
    op(4'b1001, 0, 32'h0, 0, 1, 4'd3);
    #1;
    chk("mvn_flags", {28'b0, b.status_next}, 32'h8);
    go();
    chk("mvn_res", b.alu_res, 32'hFFFF_FFFF);

    // Undefined command gives zero
    op(4'b1100, 32'h1234, 32'h5678, 0, 1, 4'd3);
    #1;
    chk("undef_z", {28'b0, b.status_next}, 32'h4);
    go();
    chk("undef_res", b.alu_res, 0);

    // valid_in=0 gives a bubble
    b.valid_in = 0;
    #1;
    chk("idle_noupd", {31'b0, b.status_update}, 0);
    go();
    chk("idle_wb", {31'b0, b.wb_en_out}, 0);

    // MLA 3*0xFFFFFFFF+10
    b.status_in = 4'b0000;
    op(4'b1011, 32'd3, 32'hFFFF_FFFF, 32'd10, 1, 4'd7);
    run_mul(n_st, n_bub);
    chk("mla_stall_cycles", n_st, 33);
    chk("mla_bubbles", n_bub, 0);
    chk("mla_done_stall", {31'b0, b.stall_out}, 0);
    chk("mla_done_upd", {31'b0, b.status_update}, 1);
    chk("mla_done_flags", {28'b0, b.status_next}, 0);
    go();
    chk("mla_res", b.alu_res, 7);
    chk("mla_wb", {31'b0, b.wb_en_out}, 1);
    chk("mla_dest", {28'b0, b.dest_out}, 7);

    // MUL ignores the accumulator input
    b.status_in = 4'b0011;
    op(4'b1010, 32'h0000_FFFF, 32'h0001_0001, 32'd5, 1, 4'd4);
    run_mul(n_st, n_bub);
    chk("mul_stall_cycles", n_st, 33);
    chk("mul_done_flags", {28'b0, b.status_next}, 32'hB);
    go();
    chk("mul_res", b.alu_res, 32'hFFFF_FFFF);

    // MUL 6*7 flushed in the 5th BUSY cycle
    op(4'b1010, 32'd6, 32'd7, 0, 1, 4'd5);
    #1;
    chk("fl_start_stall", {31'b0, b.stall_out}, 1);
    go();
    repeat (4) go();
    chk("fl_busy5_stall", {31'b0, b.stall_out}, 1);
    b.flush = 1'b1;
    #1;
    chk("fl_noupd", {31'b0, b.status_update}, 0);
    go();
    b.flush = 1'b0;
    b.valid_in = 1'b0;
    #1;
    chk("fl_wb", {31'b0, b.wb_en_out}, 0);
    chk("fl_stall_after", {31'b0, b.stall_out}, 0);
    op(4'b0010, 32'd2, 32'd3, 0, 0, 4'd6);
    #1;
    chk("fl_idle_stall", {31'b0, b.stall_out}, 0);
    go();
    chk("fl_next_res", b.alu_res, 5);
    chk("fl_next_wb", {31'b0, b.wb_en_out}, 1);

    // Forwarding (store data too)
    op(4'b0010, 32'd1, 32'd1, 32'h33, 0, 4'd8);
    b.mem_w_en_in = 1'b1;
    b.fwd_sel_1 = 2'b01; b.fwd_mem_val = 32'd100;
    b.fwd_sel_2 = 2'b10; b.fwd_wb_val  = 32'h55;
    go();
`ifdef EXE_FWD_EN
    chk("fwd_res", b.alu_res, 101);
    chk("fwd_rm", b.val_r_m_out, 32'h55);
`else
    chk("fwd_res", b.alu_res, 2);
    chk("fwd_rm", b.val_r_m_out, 32'h33);
`endif
    chk("fwd_memw", {31'b0, b.mem_w_en_out}, 1);
    b.mem_w_en_in = 1'b0;
    b.fwd_sel_1 = 2'b00; b.fwd_sel_2 = 2'b00;

    // Branch target
    b.pc_in = 32'h100; b.signed_imm_24 = 24'hFFFFFE;
    #1;
    chk("br_back", b.branch_addr, 32'hF8);
    b.pc_in = 32'hFFFF_FFFC; b.signed_imm_24 = 24'h000001;
    #1;
    chk("br_wrap", b.branch_addr, 0);

    // Reset mid-multiply
    op(4'b0010, 32'h12, 32'h34, 32'h56, 0, 4'd9);
    go();
    chk("pre_rst_res", b.alu_res, 32'h46);
    op(4'b1010, 32'd6, 32'd7, 0, 1, 4'd5);
    go(); go();
    rst = 1'b1;
    b.valid_in = 1'b0;
    go();
    rst = 1'b0;
    chk("rst_mid_res", b.alu_res, 0);
    chk("rst_mid_wb", {31'b0, b.wb_en_out}, 0);
    chk("rst_mid_dest", {28'b0, b.dest_out}, 0);
    chk("rst_mid_rm", b.val_r_m_out, 0);
    chk("rst_mid_stall", {31'b0, b.stall_out}, 0);
    op(4'b0010, 32'd1, 32'd1, 0, 0, 4'd1);
    #1;
    chk("post_rst_stall", {31'b0, b.stall_out}, 0);
    go();
    chk("post_rst_res", b.alu_res, 2);
    b.valid_in = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
